// File: rtl/skew_mem_pp.sv
// skew_mem_pp: double-buffered systolic-array edge memory.
// Two ping-pong banks of DIM lanes x K elements. One bank is streamed out
// in skewed (rhombus) order while the other bank is being written. Lane r
// is delayed r cycles. A start/busy/done handshake connects it to the array
// controller.
module skew_mem_pp #(
  parameter  int BITS_AB = 8,
  parameter  int DIM     = 8,
  parameter  int K       = 8,
  localparam int CW      = (K > 1) ? $clog2(K) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     WrEn,
  input  logic [CW-1:0]            Wcol,
  input  logic [DIM*BITS_AB-1:0]   Win,
  input  logic                     wr_swap,
  input  logic                     start,
  output logic [DIM*BITS_AB-1:0]   Aout,
  output logic                     out_vld,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_ready,
  output logic                     err
);

  // The stream counter runs 0..K+DIM-2. It is sized to hold K+DIM-1, so
  // that (t - r) for the largest lane offset wraps to a value >= K. That
  // lets a single unsigned compare decide whether a lane is inside the
  // rhombus.
  localparam int TW = $clog2(K + DIM);
  localparam logic [TW-1:0] T_LAST = TW'(K + DIM - 2);
  localparam logic [TW-1:0] K_T    = TW'(K);
  localparam logic [CW:0]   K_W    = (CW + 1)'(K);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_e;

  // Storage: [bank][lane][column]
  logic [BITS_AB-1:0] bank_mem [0:1][0:DIM-1][0:K-1];

  state_e                 state_q, state_d;
  logic [TW-1:0]          t_q, t_d;
  logic                   rptr_q, rptr_d;
  logic                   wptr_q, wptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [DIM*BITS_AB-1:0] aout_q, aout_d;
  logic                   out_vld_q, out_vld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rd_ready_q, rd_ready_d;
  logic                   err_q, err_d;

  logic                   stream_d;
  logic                   swap_ok;
  logic                   end_strm;
  logic                   wr_en;

  // Writes and commits are only accepted while a bank is free.
  assign swap_ok  = wr_swap && (cnt_q != 2'd2);
  assign end_strm = (state_q == S_STREAM) && (t_q == T_LAST);
  assign wr_en    = WrEn && ({1'b0, Wcol} < K_W) && (cnt_q != 2'd2);

  // Next-state logic for the FSM, bank pointers, occupancy and handshake
  // outputs.
  // NOTE: every variable gets a default at the top of the block. This way
  // no path leaves it unassigned, and no latch is inferred.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = wr_swap && !swap_ok;

    case (state_q)
      S_IDLE: begin
        if (start && (cnt_q != 2'd0)) begin
          state_d = S_STREAM;
          t_d     = '0;
        end
      end
      S_STREAM: begin
        if (t_q == T_LAST) begin
          // Retire the streamed bank. Continue without a bubble only when
          // the other bank is already committed.
          done_d = 1'b1;
          rptr_d = ~rptr_q;
          t_d    = '0;
          if (!(start && (cnt_q == 2'd2))) begin
            state_d = S_IDLE;
          end
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (swap_ok) begin
      wptr_d = ~wptr_q;
    end

    // A commit and a retire on the same edge cancel out.
    case ({swap_ok, end_strm})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    stream_d   = (state_d == S_STREAM);
    busy_d     = stream_d;
    out_vld_d  = stream_d;
    // The bank being streamed does not count as waiting.
    rd_ready_d = stream_d ? (cnt_d == 2'd2) : (cnt_d != 2'd0);
  end

  // Per-lane selection of the element for the upcoming slice.
  for (genvar r = 0; r < DIM; r++) begin : g_lane
    logic [BITS_AB-1:0] lane_d;
    logic [TW-1:0]      diff;

    // Pick M[rptr][r][t-r] inside the rhombus. Pad with zero outside it.
    always_comb begin
      lane_d = '0;
      diff   = t_d - TW'(r);
      if (stream_d && (diff < K_T)) begin
        lane_d = bank_mem[rptr_d][r][CW'(diff)];
      end
    end

    assign aout_d[r*BITS_AB +: BITS_AB] = lane_d;
  end

  // Column write into the write bank.
  // NOTE: the bank storage has no reset. Its contents are don't-care until
  // they are written and committed, and leaving out a reset keeps it a
  // plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int r = 0; r < DIM; r++) begin
        bank_mem[wptr_q][r][Wcol] <= Win[r*BITS_AB +: BITS_AB];
      end
    end
  end

  // Control state and registered outputs. Reset aborts any stream in
  // flight and discards both banks.
  // NOTE: state is updated with non-blocking assignments only. All flops
  // then sample the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
      aout_q     <= '0;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      aout_q     <= aout_d;
      out_vld_q  <= out_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_ready_q <= rd_ready_d;
      err_q      <= err_d;
    end
  end

  assign Aout     = aout_q;
  assign out_vld  = out_vld_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_ready = rd_ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_skew_mem_pp.sv
// Testbench for skew_mem_pp (DIM=4, K=6). The reference model keeps the
// pending write matrix and a queue of committed matrices. Expected slices
// come straight from the rhombus rule.
module tb_skew_mem_pp;
  localparam int BITS_AB = 8;
  localparam int DIM     = 4;
  localparam int K       = 6;
  localparam int S       = K + DIM - 1;
  localparam int CW      = 3;
  localparam int VW      = DIM * BITS_AB;
  localparam int MW      = DIM * K * BITS_AB;

  typedef logic [MW-1:0] mat_t;
  typedef logic [VW-1:0] vec_t;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          WrEn    = 1'b0;
  logic [CW-1:0] Wcol    = '0;
  vec_t          Win     = '0;
  logic          wr_swap = 1'b0;
  logic          start   = 1'b0;
  vec_t          Aout;
  logic          out_vld, busy, done, rd_ready, err;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   done_cyc[$];
  mat_t wbuf;
  mat_t q[$];

  always #5 clk = ~clk;

  skew_mem_pp #(.BITS_AB(BITS_AB), .DIM(DIM), .K(K)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .WrEn    (WrEn),
    .Wcol    (Wcol),
    .Win     (Win),
    .wr_swap (wr_swap),
    .start   (start),
    .Aout    (Aout),
    .out_vld (out_vld),
    .busy    (busy),
    .done    (done),
    .rd_ready(rd_ready),
    .err     (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t col_of(input mat_t m, input int k);
    vec_t v;
    for (int r = 0; r < DIM; r++) v[r*BITS_AB +: BITS_AB] = m[(r*K + k)*BITS_AB +: BITS_AB];
    return v;
  endfunction

  // Expected slice t: lane r shows M[r][t-r] inside the rhombus, 0 elsewhere.
  function automatic vec_t slice_of(input mat_t m, input int t);
    vec_t v;
    v = '0;
    for (int r = 0; r < DIM; r++)
      if (t - r >= 0 && t - r < K) v[r*BITS_AB +: BITS_AB] = m[(r*K + t - r)*BITS_AB +: BITS_AB];
    return v;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < DIM*K; i++) m[i*BITS_AB +: BITS_AB] = BITS_AB'($urandom);
    return m;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " Aout"},    64'(Aout),    64'(0));
    check({tag, " out_vld"}, 64'(out_vld), 64'(0));
    check({tag, " busy"},    64'(busy),    64'(0));
    check({tag, " done"},    64'(done),    64'(0));
  endtask

  task automatic write_col(input int k, input vec_t v);
    WrEn = 1'b1;
    Wcol = CW'(k);
    Win  = v;
    if (k < K && q.size() < 2)
      for (int r = 0; r < DIM; r++) wbuf[(r*K + k)*BITS_AB +: BITS_AB] = v[r*BITS_AB +: BITS_AB];
    tick();
    WrEn = 1'b0;
  endtask

  task automatic write_mat(input mat_t m);
    for (int k = 0; k < K; k++) write_col(k, col_of(m, k));
  endtask

  task automatic do_swap(input string tag);
    bit rej;
    rej = (q.size() == 2);
    wr_swap = 1'b1;
    if (!rej) q.push_back(wbuf);
    tick();
    wr_swap = 1'b0;
    check({tag, " err"},      64'(err),      64'(rej));
    check({tag, " rd_ready"}, 64'(rd_ready), 64'(q.size() >= 1));
    tick();
    check({tag, " err_pulse"}, 64'(err), 64'(0));
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks every slice of the stream of q[0]. Optionally writes and commits
  // wmat in the background, pulses start on ign1/ign2, requests back-to-back
  // on the last slice, or asserts reset at slice abort_at.
  task automatic stream(input string tag, input bit wr_during, input mat_t wmat,
                        input int ign1, input int ign2, input bit b2b, input int abort_at);
    mat_t cur;
    bit   go_on;
    cur = q[0];
    for (int t = 0; t < S; t++) begin
      if (t == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_quiet({tag, " abort"});
        check({tag, " abort rd_ready"}, 64'(rd_ready), 64'(0));
        check({tag, " abort err"},      64'(err),      64'(0));
        q.delete();
        WrEn = 1'b0; wr_swap = 1'b0; start = 1'b0;
        return;
      end
      check({tag, " slice"},    64'(Aout),     64'(slice_of(cur, t)));
      check({tag, " out_vld"},  64'(out_vld),  64'(1));
      check({tag, " busy"},     64'(busy),     64'(1));
      check({tag, " rd_ready"}, 64'(rd_ready), 64'(q.size() >= 2));
      check({tag, " err"},      64'(err),      64'(0));
      if (t > 0) check({tag, " done_early"}, 64'(done), 64'(0));
      WrEn = 1'b0; wr_swap = 1'b0; start = 1'b0;
      if (wr_during && t < K) begin
        WrEn = 1'b1;
        Wcol = CW'(t);
        Win  = col_of(wmat, t);
        if (q.size() < 2)
          for (int r = 0; r < DIM; r++)
            wbuf[(r*K + t)*BITS_AB +: BITS_AB] = Win[r*BITS_AB +: BITS_AB];
      end
      if (wr_during && t == K) begin
        wr_swap = 1'b1;
        if (q.size() < 2) q.push_back(wbuf);
      end
      if (t == ign1 || t == ign2 || (b2b && t == S - 1)) start = 1'b1;
      tick();
    end
    go_on = b2b && (q.size() == 2);
    WrEn = 1'b0; wr_swap = 1'b0; start = 1'b0;
    void'(q.pop_front());
    done_cyc.push_back(cyc);
    check({tag, " done"},     64'(done),     64'(1));
    check({tag, " busy_end"}, 64'(busy),     64'(go_on));
    check({tag, " vld_end"},  64'(out_vld),  64'(go_on));
    check({tag, " rd_end"},   64'(rd_ready), 64'(go_on ? (q.size() >= 2) : (q.size() >= 1)));
    if (!go_on) begin
      check({tag, " Aout_end"}, 64'(Aout), 64'(0));
      tick();
      check_quiet({tag, " post"});
    end
  endtask

  initial begin
    mat_t ma, mb, m1;

    // Reset held with random inputs: all outputs stay 0.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      WrEn    = 1'($urandom);
      wr_swap = 1'($urandom);
      start   = 1'($urandom);
      Wcol    = CW'($urandom);
      Win     = VW'($urandom);
      tick();
      check_quiet("rst");
      check("rst rd_ready", 64'(rd_ready), 64'(0));
      check("rst err",      64'(err),      64'(0));
    end
    WrEn = 1'b0; wr_swap = 1'b0; start = 1'b0;
    rst_n = 1'b1;
    tick();
    check_quiet("post_rst");

    // start with nothing committed is ignored.
    launch();
    check("nocommit busy", 64'(busy),    64'(0));
    check("nocommit vld",  64'(out_vld), 64'(0));
    check("nocommit err",  64'(err),     64'(0));
    tick();
    check("nocommit done", 64'(done), 64'(0));

    // Single matrix: M[r][k] = 16r+k, M[3][5] = -128. The Wcol=K write is
    // dropped.
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < K; k++) m1[(r*K + k)*BITS_AB +: BITS_AB] = 8'(16*r + k);
    m1[(3*K + 5)*BITS_AB +: BITS_AB] = 8'h80;
    write_mat(m1);
    write_col(K, {DIM{8'h55}});
    do_swap("single");
    launch();
    stream("single", 1'b0, '0, -1, -1, 1'b0, -1);

    // Ping-pong: bank1 written during the stream, back-to-back start.
    ma = rand_mat();
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < K; k++) mb[(r*K + k)*BITS_AB +: BITS_AB] = 8'(-(r + k + 1));
    write_mat(ma);
    do_swap("pp0");
    launch();
    stream("pp_a", 1'b1, mb, -1, -1, 1'b1, -1);
    stream("pp_b", 1'b0, '0, -1, -1, 1'b0, -1);
    check("pp done_gap", 64'(done_cyc[$] - done_cyc[$-1]), 64'(S));

    // Overflow: two commits, then the write and the third commit are
    // rejected. Mid-stream starts on slices 2 and 5 are ignored.
    ma = rand_mat();
    mb = rand_mat();
    write_mat(ma);
    do_swap("ov1");
    write_mat(mb);
    do_swap("ov2");
    write_col(0, {DIM{8'h7F}});
    do_swap("ov3");
    launch();
    stream("ov_a", 1'b0, '0, 2, 5, 1'b0, -1);
    check("ov_a length", 64'(done_cyc[$] - done_cyc[$-1] > S), 64'(1));
    launch();
    stream("ov_b", 1'b0, '0, -1, -1, 1'b0, -1);

    // Reset at slice 4, then a fresh matrix streams correctly.
    ma = rand_mat();
    write_mat(ma);
    do_swap("rm0");
    launch();
    stream("rst_mid", 1'b0, '0, -1, -1, 1'b0, 4);
    tick();
    check_quiet("rst_mid hold");
    rst_n = 1'b1;
    tick();
    check_quiet("rst_mid rel");
    check("rst_mid rd_ready", 64'(rd_ready), 64'(0));
    ma = rand_mat();
    write_mat(ma);
    do_swap("after_rst");
    launch();
    stream("after_rst", 1'b0, '0, -1, -1, 1'b0, -1);

    // A few random back-to-back rounds.
    for (int i = 0; i < 3; i++) begin
      ma = rand_mat();
      mb = rand_mat();
      write_mat(ma);
      do_swap("rnd0");
      launch();
      stream("rnd_a", 1'b1, mb, -1, -1, 1'b1, -1);
      stream("rnd_b", 1'b0, '0, -1, -1, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/skew_mem_pp.md
# skew_mem_pp

Double-buffered, parametrised successor to the systolic-array input memory. It stores matrices of DIM lanes by K elements in two ping-pong banks and streams one bank out in skewed (rhombus) order: lane r is delayed r cycles. The next matrix can be written while the current one streams. It feeds the left (A) or top (B) edge of the DIM-wide systolic array, with a start/busy/done handshake to the array controller.

## Interface
- BITS_AB, 8, signed element width
- DIM, 8, lane count (output vector width), ≥1
- K, 8, elements per lane (stream depth), ≥1; independent of DIM
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- WrEn  in  1  write one column into the write bank
- Wcol  in  max(1,$clog2(K))  column index k
- Win  in  [DIM-1:0] x BITS_AB signed  Win[r] → M[r][Wcol]
- wr_swap  in  1  commit the write bank
- start  in  1  request streaming of the oldest committed bank
- Aout  out  [DIM-1:0] x BITS_AB signed  skewed output vector
- out_vld  out  1  Aout carries a stream slice
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse after the last slice
- rd_ready  out  1  at least one committed bank is waiting (cnt≥1 and not counting the bank being streamed)
- err  out  1  one-cycle pulse: wr_swap rejected

## Operation
- State: two banks of DIM×K elements; wptr, rptr (1 bit each); cnt (0..2), the number of committed banks including the one streaming; stream counter t (0..K+DIM-2); FSM IDLE/STREAM.
- Write: if WrEn and Wcol<K and cnt<2, then bank[wptr][r][Wcol] ← Win[r] for all r. Wcol≥K is ignored. Writes when cnt==2 are dropped and all banks are untouched.
- wr_swap with cnt<2: cnt++, wptr toggles. A write in the same cycle lands before the commit. With cnt==2: ignored, err=1 for one cycle.
- IDLE→STREAM on start with cnt≥1. start in IDLE with cnt==0 is ignored, with no err.
- STREAM: slice t is Aout[r] = bank[rptr][r][t-r] if 0≤t-r<K, else 0. out_vld=1 for t=0..K+DIM-2, which is K+DIM-1 slices.
- End of stream, on the edge after slice K+DIM-2: done=1, rptr toggles, cnt--. If there is no back-to-back start, go to IDLE, with Aout=0 and out_vld=0.
- Back-to-back: start sampled during slice K+DIM-2 with cnt==2 starts the next bank immediately. The next cycle shows slice 0 of the new bank, with no bubble. done still pulses.
- start during STREAM on any other cycle is ignored.
- wr_swap and end-of-stream on the same edge: both pointers toggle and cnt is unchanged.
- Arithmetic: pure data movement with no sign change. Pad slots are 0.

## Timing
- Reset (async, rst_n low): Aout=0, out_vld=0, busy=0, done=0, rd_ready=0, err=0, cnt=0, wptr=rptr=0, FSM=IDLE. Bank contents are not cleared.
- Reset mid-stream aborts immediately. No done is issued and both banks are discarded.
- All outputs are registered.
- Latency: start sampled at edge n → after edge n, busy=1, out_vld=1, and Aout = slice 0. Slice t is visible after edge n+t.
- After edge n+K+DIM-1: done=1 for that cycle, and busy=0 unless back-to-back.
- The commit → rd_ready transition is 1 cycle: rd_ready rises after the wr_swap edge.
- err and done are high for exactly one cycle each.

## Test plan
- Reset: drive random inputs while rst_n=0 → all outputs 0. After release, start with no commit → busy stays 0 and no done.
- DIM=4, K=6 single matrix:
  - Stimulus: write M[r][k]=16r+k, with M[3][5] forced to -128; wr_swap; start at edge n.
  - Slices: Aout = {0,0,0,0x00} after n, {0,0,0x10,0x01} after n+1, and so on.
  - Final slice after n+8: lane 3 holds -128.
  - Handshake: out_vld is high 9 cycles, done pulses after n+9, Aout=0 after that.
- Ping-pong:
  - Stimulus: commit bank0 and start. During the stream, write and commit bank1 with M[r][k]=-(r+k+1). Assert start during the final slice.
  - Response: bank1 slice 0 appears the next cycle, with no out_vld gap. Two done pulses, 9 cycles apart.
- Overflow: commit twice without start (cnt=2), then write Win=all 0x7F to column 0 and wr_swap.
  - err pulses once.
  - Streaming both banks shows the original data, not 0x7F.
- Ignored requests:
  - start pulsed on slices 2 and 5 mid-stream → no restart; stream length stays 9.
  - Wcol=K write → no effect on streamed data.
- Reset at slice 4 → all outputs 0 on reset assertion and no done. A fresh write/commit/start then streams correctly from bank0.
